// File: rtl/write_ingress_ctrl.sv
// Write-domain ingress: 2-entry skid buffer feeding the FIFO write port, plus
// registered occupancy, almost-full and saturating accepted-word count.
module write_ingress_ctrl #(
  parameter int DSIZE        = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DSIZE-1:0]    in_data,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic [15:0]         wcount
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

  localparam logic [ADDRSIZE:0] AFULL_THRESH = (ADDRSIZE+1)'((2**ADDRSIZE) - AFULL_MARGIN);

  skid_state_e       state, state_next;
  logic [DSIZE-1:0]  head_q, tail_q;
  logic              accept, pop;
  logic              load_head, head_from_tail, load_tail;
  logic [ADDRSIZE:0] lvl;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Reset is gated in so a mid-operation reset never pushes a discarded word.
  assign winc   = (state != EMPTY) && !wfull && !wrst;
  assign pop    = winc;
  assign accept = in_valid && in_ready;
  assign wdata  = head_q;
  assign lvl    = gray2bin(wptr) - gray2bin(wq2_rptr);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_next = ONE;
        load_head  = 1'b1;
      end
      ONE: begin
        if (accept && !pop) begin
          state_next = TWO;
          load_tail  = 1'b1;
        end else if (!accept && pop) begin
          state_next = EMPTY;
        end else if (accept && pop) begin
          load_head = 1'b1;
        end
      end
      TWO: if (pop) begin
        state_next     = ONE;
        load_head      = 1'b1;
        head_from_tail = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state        <= EMPTY;
      in_ready     <= 1'b0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      state        <= state_next;
      in_ready     <= (state_next != TWO);
      wlevel       <= lvl;
      walmost_full <= (lvl >= AFULL_THRESH);
      if (accept && (wcount != 16'hFFFF)) wcount <= wcount + 16'd1;
    end
  end

  // NOTE: buffer storage is deliberately not reset; its contents are qualified by state.
  always_ff @(posedge wclk) begin
    if (load_head) head_q <= head_from_tail ? tail_q : in_data;
    if (load_tail) tail_q <= in_data;
  end

endmodule

// File: tb/tb_write_ingress_ctrl.sv
// Directed self-checking bench for write_ingress_ctrl: reset, single word,
// backpressure, streaming, level/almost-full, pointer wrap and mid-run reset.
module tb_write_ingress_ctrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       wfull;
  logic [4:0] wptr;
  logic [4:0] wq2_rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] wlevel;
  logic       walmost_full;
  logic [15:0] wcount;

  int errors = 0;
  int checks = 0;

  write_ingress_ctrl #(.DSIZE(8), .ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk(wclk), .wrst(wrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
    .winc(winc), .wdata(wdata),
    .wlevel(wlevel), .walmost_full(walmost_full), .wcount(wcount)
  );

  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1; in_valid = 1'b0; wfull = 1'b0; wptr = '0; wq2_rptr = '0;
    tick();
    wrst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    wrst = 1'b1; in_valid = 1'b0; in_data = '0; wfull = 1'b0; wptr = '0; wq2_rptr = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rst_winc: got %b expected 0", winc); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL rst_wlevel: got %0d expected 0", wlevel); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b expected 0", walmost_full); end
    checks++; if (wcount !== 16'd0) begin errors++; $display("FAIL rst_wcount: got %0d expected 0", wcount); end
    wrst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL idle_winc: got %b expected 0", winc); end
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    #1;
    checks++; if (winc !== 1'b1) begin errors++; $display("FAIL single_winc: got %b expected 1", winc); end
    checks++; if (wdata !== 8'hA5) begin errors++; $display("FAIL single_wdata: got %h expected a5", wdata); end
    tick();
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL single_winc_after: got %b expected 0", winc); end
    checks++; if (wcount !== 16'd1) begin errors++; $display("FAIL single_wcount: got %0d expected 1", wcount); end
  endtask

  task automatic test_backpressure();
    wfull = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_data = 8'h03;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL bp_winc_held: got %b expected 0", winc); end
    checks++; if (wcount !== 16'd3) begin errors++; $display("FAIL bp_wcount_held: got %0d expected 3", wcount); end
    wfull = 1'b0;
    #1;
    checks++; if (winc !== 1'b1 || wdata !== 8'h01) begin errors++; $display("FAIL bp_first: got winc=%b data=%h expected winc=1 data=01", winc, wdata); end
    tick();
    checks++; if (winc !== 1'b1 || wdata !== 8'h02) begin errors++; $display("FAIL bp_second: got winc=%b data=%h expected winc=1 data=02", winc, wdata); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (winc !== 1'b1 || wdata !== 8'h03) begin errors++; $display("FAIL bp_third: got winc=%b data=%h expected winc=1 data=03", winc, wdata); end
    tick();
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", winc); end
    checks++; if (wcount !== 16'd4) begin errors++; $display("FAIL bp_wcount: got %0d expected 4", wcount); end
  endtask

  task automatic test_streaming();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      tick();
      if (winc !== 1'b1 || wdata !== (8'h40 + 8'(i)) || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_word%0d: got winc=%b data=%h ready=%b expected winc=1 data=%h ready=1",
                 i, winc, wdata, in_ready, 8'h40 + 8'(i));
      end
    end
    checks++; if (bad != 0) errors++;
    in_valid = 1'b0;
    tick();
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b expected 0", winc); end
    checks++; if (wcount !== 16'd20) begin errors++; $display("FAIL stream_wcount: got %0d expected 20", wcount); end
  endtask

  task automatic test_level_afull();
    wptr = 5'b11011; wq2_rptr = 5'b00110;
    tick();
    checks++; if (wlevel !== 5'd14) begin errors++; $display("FAIL lvl14: got %0d expected 14", wlevel); end
    checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL afull_set: got %b expected 1", walmost_full); end
    wq2_rptr = 5'b00111;
    tick();
    checks++; if (wlevel !== 5'd13) begin errors++; $display("FAIL lvl13: got %0d expected 13", wlevel); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL afull_clr: got %b expected 0", walmost_full); end
  endtask

  task automatic test_wrap_and_reset();
    wptr = 5'b00011; wq2_rptr = 5'b10001;
    tick();
    checks++; if (wlevel !== 5'd4) begin errors++; $display("FAIL wrap_lvl: got %0d expected 4", wlevel); end
    wfull = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_data = 8'hBB;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_two_held: got %b expected 0", in_ready); end
    wrst = 1'b1; wfull = 1'b0;
    #1;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL mid_rst_winc_pre: got %b expected 0", winc); end
    tick();
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL mid_rst_winc: got %b expected 0", winc); end
    checks++; if (wcount !== 16'd0) begin errors++; $display("FAIL mid_rst_wcount: got %0d expected 0", wcount); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL mid_rst_wlevel: got %0d expected 0", wlevel); end
    wrst = 1'b0; wptr = '0; wq2_rptr = '0;
    tick();
    checks++; if (in_ready !== 1'b1 || winc !== 1'b0) begin errors++; $display("FAIL post_rst: got ready=%b winc=%b expected ready=1 winc=0", in_ready, winc); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_streaming();
    test_level_afull();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
